// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the byte-serial fp32 multiplier loader.
package fp_mul_pkg;

    localparam int FP_W           = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = FP_W / BYTE_W;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        SEND    = 2'd3
    } state_t;

    // Shift one byte into an assembly register in the selected byte order.
    function automatic logic [FP_W-1:0] shift_in(input logic [FP_W-1:0] r,
                                                 input logic [BYTE_W-1:0] b,
                                                 input bit msb_first);
        if (msb_first) return {r[FP_W-BYTE_W-1:0], b};
        else           return {b, r[FP_W-1:BYTE_W]};
    endfunction

endpackage

// File: rtl/fp_byte_serializer.sv
// 32-bit word to 8-bit valid/ready byte stream, one word per load.
module fp_byte_serializer
    import fp_mul_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [FP_W-1:0]   word_i,
    output logic [BYTE_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              done_o
);

    logic [FP_W-1:0] sh;
    logic [1:0]      cnt;
    logic            hs;

    assign hs         = out_valid_o && out_ready_i;
    assign done_o     = hs && (cnt == 2'(BYTES_PER_WORD-1));
    assign out_data_o = MSB_FIRST ? sh[FP_W-1 -: BYTE_W] : sh[BYTE_W-1:0];

    // Shift register walks the current byte to the output end on each handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh          <= '0;
            cnt         <= '0;
            out_valid_o <= 1'b0;
        end else if (load_i) begin
            sh          <= word_i;
            cnt         <= '0;
            out_valid_o <= 1'b1;
        end else if (hs) begin
            sh  <= MSB_FIRST ? {sh[FP_W-BYTE_W-1:0], {BYTE_W{1'b0}}}
                             : {{BYTE_W{1'b0}}, sh[FP_W-1:BYTE_W]};
            cnt <= cnt + 2'd1;
            if (done_o) out_valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_mul_stream_loader.sv
// Byte-serial operand loader / result streamer around a combinational fp32 multiplier.
module fp_mul_stream_loader
    import fp_mul_pkg::*;
#(
    parameter int COMPUTE_CYCLES = 1,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BYTE_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [FP_W-1:0]   a_o,
    output logic [FP_W-1:0]   b_o,
    input  logic [FP_W-1:0]   mul_c_i,
    output logic [BYTE_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [FP_W-1:0]   result_o,
    output logic              result_valid_o,
    output logic              busy_o
);

    localparam int              WW        = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(COMPUTE_CYCLES - 1);

    state_t          state, state_nx;
    logic [1:0]      byte_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [FP_W-1:0] a_reg, b_reg;
    logic            accept, last_byte, capture, send_done;

    // Ready is a pure state decode so the source never sees a combinational path.
    assign in_ready_o = (state == LOAD_A) || (state == LOAD_B);
    assign busy_o     = (state == COMPUTE) || (state == SEND);
    assign accept     = in_valid_i && in_ready_o;
    assign last_byte  = (byte_cnt == 2'(BYTES_PER_WORD-1));
    assign a_o        = a_reg;
    assign b_o        = b_reg;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= LOAD_A;
        else       state <= state_nx;
    end

    // Next-state decode and capture strobe.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            LOAD_A:  if (accept && last_byte) state_nx = LOAD_B;
            LOAD_B:  if (accept && last_byte) state_nx = COMPUTE;
            COMPUTE: if (wait_cnt == WAIT_LAST) begin
                         capture  = 1'b1;
                         state_nx = SEND;
                     end
            SEND:    if (send_done) state_nx = LOAD_A;
            default: state_nx = LOAD_A;
        endcase
    end

    // Byte counter for operand assembly and settle counter for COMPUTE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) byte_cnt <= last_byte ? 2'd0 : byte_cnt + 2'd1;
            if (state == LOAD_B && accept && last_byte) wait_cnt <= '0;
            else if (state == COMPUTE && !capture)      wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Operand assembly; registers hold between operations so the core input stays stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (accept) begin
            if (state == LOAD_A) a_reg <= shift_in(a_reg, in_data_i, MSB_FIRST);
            else                 b_reg <= shift_in(b_reg, in_data_i, MSB_FIRST);
        end
    end

    // Product capture and one-cycle capture pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            result_valid_o <= capture;
            if (capture) result_o <= mul_c_i;
        end
    end

    fp_byte_serializer #(.MSB_FIRST(MSB_FIRST)) u_ser (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (capture),
        .word_i      (mul_c_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .done_o      (send_done)
    );

endmodule

// File: doc/fp_mul_stream_loader.md
Name: fp_mul_stream_loader

Overview:
Byte-serial front/back end for the combinational fp32 multiplier core. Assembles two 32-bit IEEE-754 operands from an 8-bit valid/ready input stream and drives them to the multiplier. After a programmable settle time it captures the 32-bit product and streams it out as 4 bytes on an 8-bit valid/ready output. Sits between the system byte link (UART/SPI bridge) and the multiplier core. Only one operation is in flight at a time.

Parameters:
COMPUTE_CYCLES, 1, cycles between last operand byte accepted and product capture (≥1; covers core combinational settle or future pipelining)
MSB_FIRST, 1, 1 = most-significant byte first on both streams; 0 = least-significant byte first

Ports:
clk_i  input  1  clock; all logic rising-edge
rst_i  input  1  synchronous active-high reset
in_data_i  input  8  operand byte
in_valid_i  input  1  in_data_i valid
in_ready_o  output  1  loader accepts a byte this cycle
a_o  output  32  operand A to multiplier
b_o  output  32  operand B to multiplier
mul_c_i  input  32  product from multiplier
out_data_o  output  8  result byte
out_valid_o  output  1  out_data_o valid
out_ready_i  input  1  downstream accepts byte
result_o  output  32  last captured product (holds until next capture)
result_valid_o  output  1  one-cycle pulse on capture
busy_o  output  1  high in COMPUTE and SEND

Behaviour:
- Reset (sync, rst_i high at edge): state=LOAD_A, byte_cnt=0, wait_cnt=0, a_o=0, b_o=0, result_o=0, out_data_o=0, out_valid_o=0, result_valid_o=0, busy_o=0. Reset in any state, including mid-load or mid-send, discards all partial data. No output byte is emitted after reset.
- Accept: a byte is taken when in_valid_i && in_ready_o. in_ready_o=1 iff state ∈ {LOAD_A, LOAD_B}, decoded from state only, with no dependence on in_valid_i.
- Assembly with MSB_FIRST=1: reg <= {reg[23:0], byte}. With MSB_FIRST=0: reg <= {byte, reg[31:8]}. A and B each take exactly 4 bytes. Input gaps (in_valid_i low) are allowed anywhere.
- a_o and b_o are driven directly from the assembly registers. They change only on accepted bytes and are stable from the last B byte until the next LOAD_A accept.
- States:
  - LOAD_A: on 4th accept, byte_cnt→0 and go to LOAD_B.
  - LOAD_B: on 4th accept, wait_cnt→0 and go to COMPUTE.
  - COMPUTE: in_ready_o=0, busy_o=1, wait_cnt increments each cycle. When wait_cnt==COMPUTE_CYCLES-1: result_o<=mul_c_i, result_valid_o pulses next cycle, load send shift register, go to SEND.
  - SEND: out_valid_o=1. out_data_o = current byte: result[31:24] first if MSB_FIRST, else result[7:0]. On out_valid_o && out_ready_i, advance to the next byte. out_data_o and out_valid_o are held stable while out_ready_i is low. On the 4th handshake: out_valid_o→0, busy_o→0, go to LOAD_A (in_ready_o high the next cycle).
- Latency: with COMPUTE_CYCLES=1 and out_ready_i held high, the first result byte is valid 2 cycles after the last B byte handshake. The 4 bytes go out on consecutive cycles.
- No arithmetic is done here; mul_c_i is captured bit-exact. Counters are 2-bit (byte_cnt) and $clog2(COMPUTE_CYCLES+1)-bit (wait_cnt); neither wraps inside a state.
- Input bytes offered during COMPUTE or SEND are not accepted and must be held by the source per the handshake.

Decomposition:
- Shared package fp_mul_pkg holds:
  - state enum (LOAD_A, LOAD_B, COMPUTE, SEND)
  - BYTES_PER_WORD=4
  - FP_W=32
- One natural sub-module: fp_byte_serializer, a 32→8 shift/handshake unit used for the SEND path.
- Top instantiates fp_mul_stream_loader next to fp_multiply. No other hierarchy.

Test Plan:
- Reset, then bytes 40 00 00 00 40 40 00 00 (2.0, 3.0), out_ready_i=1 → a_o=0x40000000, b_o=0x40400000; result_o=0x40C00000, result_valid_o one pulse; out bytes 40 C0 00 00 on consecutive cycles.
- Bytes BF C0 00 00 40 00 00 00 (-1.5×2.0) with random in_valid_i gaps → output C0 40 00 00, in_ready_o low from COMPUTE until the 4th output handshake.
- Backpressure: hold out_ready_i=0 for 5 cycles after the first result byte → out_data_o=0x40 and out_valid_o=1 stable throughout; no byte lost or duplicated.
- Reset asserted after 2 B bytes → all outputs at reset values, and the next 8 bytes form a fresh A and B, with no stale bytes mixed in.
- COMPUTE_CYCLES=3, MSB_FIRST=0, bytes 00 00 80 3F 00 00 80 3F (1.0×1.0) → result_o captured exactly 3 cycles after the last B accept; output bytes 00 00 80 3F.
- Back-to-back operations → the second operand stream is accepted only after the 4th result byte, and both results are correct.
